// File: rtl/conv_pkg.sv
// Shared types and default layer constants for the convolution address generator.
// ng_calc gives the number of PE_CH-wide channel groups that cover IN_CH.
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DEF_K        = 5;
  localparam int DEF_IN_SIZE  = 32;
  localparam int DEF_OUT_SIZE = 28;
  localparam int DEF_IN_CH    = 1;
  localparam int DEF_OUT_CH   = 6;
  localparam int DEF_PE_CH    = 4;

  function automatic int ng_calc(input int in_ch, input int pe_ch);
    return (in_ch + pe_ch - 1) / pe_ch;
  endfunction

endpackage

// File: rtl/conv_addr_gen_if.sv
// Scheduler/buffer-side bundle of the address generator: control, tap addresses, output write.
// master = layer scheduler view, slave = the generator itself.
interface conv_addr_gen_if #(
  parameter int ADDR_W = 16
);
  logic              start;
  logic              stall;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] ifm_addr;
  logic [ADDR_W-1:0] weight_addr;
  logic              addr_valid;
  logic              acc_clear;
  logic              acc_enable;
  logic [ADDR_W-1:0] out_addr;
  logic              out_wea;

  modport master (
    output start, stall,
    input  busy, done, ifm_addr, weight_addr, addr_valid, acc_clear, acc_enable, out_addr, out_wea
  );

  modport slave (
    input  start, stall,
    output busy, done, ifm_addr, weight_addr, addr_valid, acc_clear, acc_enable, out_addr, out_wea
  );
endinterface

// File: rtl/conv_addr_gen_pipe_delay.sv
// Fixed-depth shift register (DEPTH cycles, no stall input, shifts every cycle).
// Async active-low clear empties every stage.
module pipe_delay #(
  parameter int W     = 1,
  parameter int DEPTH = 1
) (
  input  logic         clock,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] stg_q [DEPTH];

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < DEPTH; s++) stg_q[s] <= '0;
    end else begin
      stg_q[0] <= d_i;
      for (int s = 1; s < DEPTH; s++) stg_q[s] <= stg_q[s-1];
    end
  end

  assign q_o = stg_q[DEPTH-1];

endmodule

// File: rtl/conv_addr_gen.sv
// Convolution loop-nest sequencer: one tap per unstalled RUN cycle, addresses registered (2-cycle start latency),
// stall freezes the nest; output write trails the last tap of a pixel by OUT_DELAY. CONV_PERF_CNT_EN adds perf counters.
module conv_addr_gen
  import conv_pkg::*;
#(
  parameter int K         = DEF_K,
  parameter int IN_SIZE   = DEF_IN_SIZE,
  parameter int OUT_SIZE  = DEF_OUT_SIZE,
  parameter int IN_CH     = DEF_IN_CH,
  parameter int OUT_CH    = DEF_OUT_CH,
  parameter int PE_CH     = DEF_PE_CH,
  parameter int ADDR_W    = 16,
  parameter int OUT_DELAY = 9
) (
  input  logic           clock,
  input  logic           rst_n,
  conv_addr_gen_if.slave bus
`ifdef CONV_PERF_CNT_EN
  ,
  output logic [31:0]    perf_cycles,
  output logic [31:0]    perf_stalls
`endif
);

  localparam int NG = ng_calc(IN_CH, PE_CH);
  localparam int CW = ADDR_W;
  localparam int AW = ADDR_W + 4;
  localparam int DW = $clog2(OUT_DELAY + 1);

  localparam logic [CW-1:0] K_M1   = CW'(K - 1);
  localparam logic [CW-1:0] NG_M1  = CW'(NG - 1);
  localparam logic [CW-1:0] O_M1   = CW'(OUT_SIZE - 1);
  localparam logic [CW-1:0] M_M1   = CW'(OUT_CH - 1);
  localparam logic [DW-1:0] DR_END = DW'(OUT_DELAY);

  state_t            state_q, state_d;
  logic [CW-1:0]     m_q, r_q, c_q, ng_q, i_q, j_q;
  logic [CW-1:0]     m_d, r_d, c_d, ng_d, i_d, j_d;
  logic [DW-1:0]     drain_q, drain_d;

  logic              vld_q, clr_q, last_q;
  logic [ADDR_W-1:0] ifm_q, wt_q, oaddr_q;
  logic [ADDR_W-1:0] ifm_d, wt_d, oaddr_d;
  logic [ADDR_W:0]   dly_q;

  logic issue, busy;
  logic j_end, i_end, ng_end, c_end, r_end, m_end, pix_last, layer_last;

  assign issue      = (state_q == RUN) && !bus.stall;
  assign busy       = (state_q == RUN) || (state_q == DRAIN);
  assign j_end      = (j_q == K_M1);
  assign i_end      = (i_q == K_M1);
  assign ng_end     = (ng_q == NG_M1);
  assign c_end      = (c_q == O_M1);
  assign r_end      = (r_q == O_M1);
  assign m_end      = (m_q == M_M1);
  assign pix_last   = j_end && i_end && ng_end;
  assign layer_last = pix_last && c_end && r_end && m_end;

  always_comb begin
    state_d = state_q;
    drain_d = '0;
    m_d  = m_q;
    r_d  = r_q;
    c_d  = c_q;
    ng_d = ng_q;
    i_d  = i_q;
    j_d  = j_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          m_d  = '0;
          r_d  = '0;
          c_d  = '0;
          ng_d = '0;
          i_d  = '0;
          j_d  = '0;
        end
      end
      RUN: begin
        if (issue) begin
          // Odometer: each counter wraps and carries into the next outer one.
          j_d = j_end ? '0 : j_q + 1'b1;
          if (j_end) begin
            i_d = i_end ? '0 : i_q + 1'b1;
            if (i_end) begin
              ng_d = ng_end ? '0 : ng_q + 1'b1;
              if (ng_end) begin
                c_d = c_end ? '0 : c_q + 1'b1;
                if (c_end) begin
                  r_d = r_end ? '0 : r_q + 1'b1;
                  if (r_end) m_d = m_end ? '0 : m_q + 1'b1;
                end
              end
            end
          end
          if (layer_last) state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Count covers the registered last tap plus every delay stage.
        drain_d = drain_q + 1'b1;
        if (drain_q == DR_END) begin
          state_d = DONE;
          drain_d = '0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ifm_d   = ADDR_W'(AW'(ng_q) * AW'(IN_SIZE * IN_SIZE)
                    + (AW'(r_q) + AW'(i_q)) * AW'(IN_SIZE)
                    + AW'(c_q) + AW'(j_q));
    wt_d    = ADDR_W'(AW'(m_q) * AW'(NG * K * K) + AW'(ng_q) * AW'(K * K)
                    + AW'(i_q) * AW'(K) + AW'(j_q));
    oaddr_d = ADDR_W'(AW'(m_q) * AW'(OUT_SIZE * OUT_SIZE) + AW'(r_q) * AW'(OUT_SIZE)
                    + AW'(c_q));
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      drain_q <= '0;
      m_q     <= '0;
      r_q     <= '0;
      c_q     <= '0;
      ng_q    <= '0;
      i_q     <= '0;
      j_q     <= '0;
      vld_q   <= 1'b0;
      clr_q   <= 1'b0;
      last_q  <= 1'b0;
      ifm_q   <= '0;
      wt_q    <= '0;
      oaddr_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      m_q     <= m_d;
      r_q     <= r_d;
      c_q     <= c_d;
      ng_q    <= ng_d;
      i_q     <= i_d;
      j_q     <= j_d;
      vld_q   <= issue;
      clr_q   <= issue && (i_q == '0) && (j_q == '0) && (ng_q == '0);
      last_q  <= issue && pix_last;
      if (issue) begin
        ifm_q <= ifm_d;
        wt_q  <= wt_d;
      end
      if (issue && pix_last) oaddr_q <= oaddr_d;
    end
  end

  pipe_delay #(
    .W     (ADDR_W + 1),
    .DEPTH (OUT_DELAY)
  ) u_dly (
    .clock (clock),
    .rst_n (rst_n),
    .d_i   ({last_q, oaddr_q}),
    .q_o   (dly_q)
  );

  assign bus.busy        = busy;
  assign bus.done        = (state_q == DONE);
  assign bus.ifm_addr    = ifm_q;
  assign bus.weight_addr = wt_q;
  assign bus.addr_valid  = vld_q;
  assign bus.acc_enable  = vld_q;
  assign bus.acc_clear   = clr_q;
  assign bus.out_wea     = dly_q[ADDR_W];
  assign bus.out_addr    = dly_q[ADDR_W-1:0];

`ifdef CONV_PERF_CNT_EN
  logic [31:0] pcyc_q, pstl_q;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      pcyc_q <= '0;
      pstl_q <= '0;
    end else if ((state_q == IDLE) && bus.start) begin
      pcyc_q <= '0;
      pstl_q <= '0;
    end else begin
      if (busy) pcyc_q <= pcyc_q + 32'd1;
      if ((state_q == RUN) && bus.stall) pstl_q <= pstl_q + 32'd1;
    end
  end

  assign perf_cycles = pcyc_q;
  assign perf_stalls = pstl_q;
`endif

endmodule

// File: tb/tb_conv_addr_gen.sv
// Bench for conv_addr_gen: DUT A (NG=1, two output channels) and DUT B (NG=2) on small layers,
// monitored tap/write/done streams compared to hand tables and a loop-nest reference.
module tb_conv_addr_gen;

  typedef struct { int ifm; int wt; bit clr; int stamp; } tap_t;
  typedef struct { int addr; int stamp; } wr_t;
  typedef struct { bit sel; int idx; int ifm; int wt; bit clr; } vec_t;

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  always #5 clock = ~clock;

  int n_chk = 0;
  int n_bad = 0;
  int edge_n = 0;
  bit sel = 1'b0;

  tap_t taps[$];
  wr_t  wrs[$];
  int   dones[$];
  int   busy_n = 0;
  int   en_bad = 0;
  int   frz_bad = 0;

  conv_addr_gen_if #(.ADDR_W(16)) ia ();
  conv_addr_gen_if #(.ADDR_W(16)) ib ();

`ifdef CONV_PERF_CNT_EN
  logic [31:0] pc_a, ps_a, pc_b, ps_b;
`endif

  conv_addr_gen #(
    .K(2), .IN_SIZE(4), .OUT_SIZE(3), .IN_CH(1), .OUT_CH(2), .PE_CH(4), .ADDR_W(16), .OUT_DELAY(3)
  ) dut_a (
    .clock(clock), .rst_n(rst_n), .bus(ia.slave)
`ifdef CONV_PERF_CNT_EN
    , .perf_cycles(pc_a), .perf_stalls(ps_a)
`endif
  );

  conv_addr_gen #(
    .K(2), .IN_SIZE(4), .OUT_SIZE(3), .IN_CH(6), .OUT_CH(1), .PE_CH(4), .ADDR_W(16), .OUT_DELAY(3)
  ) dut_b (
    .clock(clock), .rst_n(rst_n), .bus(ib.slave)
`ifdef CONV_PERF_CNT_EN
    , .perf_cycles(pc_b), .perf_stalls(ps_b)
`endif
  );

  always @(posedge clock) edge_n <= edge_n + 1;

  // Stream monitor on the selected DUT, sampled mid-cycle.
  always @(negedge clock) begin
    tap_t t;
    wr_t  w;
    logic vld, en, clr, wea, dn, bsy;
    logic [15:0] ifm, wt, oa;
    vld = sel ? ib.addr_valid  : ia.addr_valid;
    en  = sel ? ib.acc_enable  : ia.acc_enable;
    clr = sel ? ib.acc_clear   : ia.acc_clear;
    wea = sel ? ib.out_wea     : ia.out_wea;
    dn  = sel ? ib.done        : ia.done;
    bsy = sel ? ib.busy        : ia.busy;
    ifm = sel ? ib.ifm_addr    : ia.ifm_addr;
    wt  = sel ? ib.weight_addr : ia.weight_addr;
    oa  = sel ? ib.out_addr    : ia.out_addr;
    if (en !== vld) en_bad++;
    if (vld) begin
      t.ifm = int'(ifm); t.wt = int'(wt); t.clr = clr; t.stamp = edge_n;
      taps.push_back(t);
    end else if (taps.size() > 0) begin
      if (int'(ifm) != taps[$].ifm || int'(wt) != taps[$].wt) frz_bad++;
    end
    if (wea) begin
      w.addr = int'(oa); w.stamp = edge_n;
      wrs.push_back(w);
    end
    if (dn) dones.push_back(edge_n);
    if (bsy) busy_n++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drv_start(input logic v);
    if (sel) ib.start = v; else ia.start = v;
  endtask

  task automatic drv_stall(input logic v);
    if (sel) ib.stall = v; else ia.stall = v;
  endtask

  int bt, bw, bd, bb, bf, be;

  task automatic mark();
    bt = taps.size(); bw = wrs.size(); bd = dones.size();
    bb = busy_n; bf = frz_bad; be = en_bad;
  endtask

  task automatic run_layer(input int stall_at, input int stall_len, input int xstart_at, output int t0);
    mark();
    @(posedge clock); #1; drv_start(1'b1);
    @(posedge clock); #1; t0 = edge_n; drv_start(1'b0);
    if (stall_len > 0) begin
      repeat (stall_at) @(posedge clock);
      #1; drv_stall(1'b1);
      repeat (stall_len) @(posedge clock);
      #1; drv_stall(1'b0);
    end
    if (xstart_at > 0) begin
      repeat (xstart_at) @(posedge clock);
      #1; drv_start(1'b1);
      @(posedge clock);
      #1; drv_start(1'b0);
    end
    for (int k = 0; k < 600 && dones.size() == bd; k++) @(posedge clock);
    chk("done_seen", int'(dones.size() > bd), 1);
    repeat (6) @(posedge clock);
  endtask

  task automatic check_layer(input int t0, input int k, input int isz, input int osz,
                             input int ng, input int och, input int dly, input int stl);
    int total, npix, idx, err, werr, last_w;
    total = och * osz * osz * ng * k * k;
    npix  = och * osz * osz;
    chk("tap_count", taps.size() - bt, total);
    if (taps.size() > bt) chk("first_tap_latency", taps[bt].stamp - t0, 1);
    idx = 0; err = 0;
    for (int m = 0; m < och; m++)
      for (int r = 0; r < osz; r++)
        for (int c = 0; c < osz; c++)
          for (int g = 0; g < ng; g++)
            for (int i = 0; i < k; i++)
              for (int j = 0; j < k; j++) begin
                if (bt + idx < taps.size()) begin
                  if (taps[bt+idx].ifm != g*isz*isz + (r+i)*isz + (c+j)) err++;
                  if (taps[bt+idx].wt != m*ng*k*k + g*k*k + i*k + j) err++;
                  if (taps[bt+idx].clr != (g == 0 && i == 0 && j == 0)) err++;
                end
                idx++;
              end
    chk("tap_sequence_errors", err, 0);
    chk("write_count", wrs.size() - bw, npix);
    werr = 0;
    for (int p = 0; p < npix; p++) begin
      if (bw + p < wrs.size() && bt + (p+1)*ng*k*k - 1 < taps.size()) begin
        if (wrs[bw+p].addr != p) werr++;
        if (wrs[bw+p].stamp != taps[bt + (p+1)*ng*k*k - 1].stamp + dly) werr++;
      end
    end
    chk("write_sequence_errors", werr, 0);
    chk("done_pulses", dones.size() - bd, 1);
    last_w = (wrs.size() > 0) ? wrs[$].stamp : 0;
    if (dones.size() > bd) begin
      chk("done_after_last_write", dones[bd] - last_w, 1);
      chk("done_time", dones[bd] - t0, total + stl + dly + 1);
    end
    chk("busy_cycles", busy_n - bb, total + stl + dly + 1);
    chk("acc_enable_eq_valid", en_bad - be, 0);
  endtask

  task automatic apply_table(input bit s, input vec_t vt[]);
    foreach (vt[v]) begin
      if (vt[v].sel == s) begin
        if (bt + vt[v].idx < taps.size()) begin
          chk($sformatf("vec%0d_ifm", v), taps[bt+vt[v].idx].ifm, vt[v].ifm);
          chk($sformatf("vec%0d_wt", v),  taps[bt+vt[v].idx].wt,  vt[v].wt);
          chk($sformatf("vec%0d_clr", v), int'(taps[bt+vt[v].idx].clr), int'(vt[v].clr));
        end else begin
          chk($sformatf("vec%0d_present", v), 0, 1);
        end
      end
    end
  endtask

  initial begin
    vec_t vt[];
    int t0;
    vt = new[23];
    // A: first pixel, pixel (0,1), first pixel of m=1, final tap
    vt[0]  = '{0, 0, 0, 0, 1};  vt[1]  = '{0, 1, 1, 1, 0};
    vt[2]  = '{0, 2, 4, 2, 0};  vt[3]  = '{0, 3, 5, 3, 0};
    vt[4]  = '{0, 4, 1, 0, 1};  vt[5]  = '{0, 5, 2, 1, 0};
    vt[6]  = '{0, 6, 5, 2, 0};  vt[7]  = '{0, 7, 6, 3, 0};
    vt[8]  = '{0, 36, 0, 4, 1}; vt[9]  = '{0, 37, 1, 5, 0};
    vt[10] = '{0, 38, 4, 6, 0}; vt[11] = '{0, 39, 5, 7, 0};
    vt[12] = '{0, 71, 15, 7, 0};
    // B: two channel groups, second group offset by 16
    vt[13] = '{1, 0, 0, 0, 1};  vt[14] = '{1, 1, 1, 1, 0};
    vt[15] = '{1, 2, 4, 2, 0};  vt[16] = '{1, 3, 5, 3, 0};
    vt[17] = '{1, 4, 16, 4, 0}; vt[18] = '{1, 5, 17, 5, 0};
    vt[19] = '{1, 6, 20, 6, 0}; vt[20] = '{1, 7, 21, 7, 0};
    vt[21] = '{1, 8, 1, 0, 1};  vt[22] = '{1, 71, 31, 7, 0};

    ia.start = 1'b0; ia.stall = 1'b0;
    ib.start = 1'b0; ib.stall = 1'b0;
    #3;
    chk("reset_ctrl_a", int'({ia.busy, ia.done, ia.addr_valid, ia.acc_clear, ia.acc_enable, ia.out_wea}), 0);
    chk("reset_addr_a", int'(ia.ifm_addr) + int'(ia.weight_addr) + int'(ia.out_addr), 0);
    chk("reset_ctrl_b", int'({ib.busy, ib.done, ib.addr_valid, ib.out_wea}), 0);
    #19 rst_n = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("idle_after_reset", int'(ia.busy), 0);

    sel = 1'b0;
    run_layer(0, 0, 0, t0);
    check_layer(t0, 2, 4, 3, 1, 2, 3, 0);
    apply_table(1'b0, vt);

    run_layer(10, 5, 0, t0);
    check_layer(t0, 2, 4, 3, 1, 2, 3, 5);
    chk("stall_frozen_addr", frz_bad - bf, 0);
    if (taps.size() > bt + 10) chk("stall_gap", taps[bt+10].stamp - taps[bt+9].stamp, 6);
`ifdef CONV_PERF_CNT_EN
    chk("perf_stalls", int'(ps_a), 5);
    chk("perf_cycles", int'(pc_a), busy_n - bb);
`endif

    sel = 1'b1;
    repeat (2) @(posedge clock);
    run_layer(0, 0, 0, t0);
    check_layer(t0, 2, 4, 3, 2, 1, 3, 0);
    apply_table(1'b1, vt);

    sel = 1'b0;
    repeat (2) @(posedge clock);
    mark();
    @(posedge clock); #1; drv_start(1'b1);
    @(posedge clock); #1; drv_start(1'b0);
    repeat (20) @(posedge clock);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_async_ctrl", int'({ia.busy, ia.done, ia.addr_valid, ia.acc_clear, ia.acc_enable, ia.out_wea}), 0);
    chk("rst_async_ifm", int'(ia.ifm_addr), 0);
    chk("rst_async_wt", int'(ia.weight_addr), 0);
    chk("rst_async_oaddr", int'(ia.out_addr), 0);
    repeat (3) @(posedge clock);
    #1 rst_n = 1'b1;
    repeat (10) @(posedge clock);
    #1;
    chk("rst_no_done", dones.size() - bd, 0);
    chk("rst_stays_idle", int'(ia.busy), 0);

    run_layer(0, 0, 30, t0);
    check_layer(t0, 2, 4, 3, 1, 2, 3, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/conv_addr_gen.md
Name: conv_addr_gen

Overview:
- Parametrised convolution-layer address generator and sequencer.
- Walks the full loop nest (m, r, c, n-group, i, j) internally from a single start pulse.
- Drives input-feature-map and weight buffer addresses plus MAC accumulate controls.
- Emits output-buffer address and write strobe, delay-matched to the MAC pipeline; sits between the top-level layer scheduler and the buffers/PE array.

Parameters:
- K, 5, kernel height/width.
- IN_SIZE, 32, input feature map height/width.
- OUT_SIZE, 28, output map height/width; must equal IN_SIZE-K+1.
- IN_CH, 1, input channels.
- OUT_CH, 6, output channels.
- PE_CH, 4, input channels packed per buffer word; NG = ceil(IN_CH/PE_CH).
- ADDR_W, 16, width of every address port.
- OUT_DELAY, 9, cycles from the final-tap address to the output write (MAC pipeline depth); must be at least 1.

Ports:
- clock  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; sampled only in IDLE.
- stall  in  1  hold the loop nest; no new tap is issued while high.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse at layer completion.
- ifm_addr  out  ADDR_W  input buffer address.
- weight_addr  out  ADDR_W  weight buffer address.
- addr_valid  out  1  the addresses on ifm_addr/weight_addr are a real tap this cycle.
- acc_clear  out  1  first tap of an output pixel (i=j=ng=0); accumulator loads instead of adding.
- acc_enable  out  1  equals addr_valid.
- out_addr  out  ADDR_W  output buffer address.
- out_wea  out  1  output buffer write enable.

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE; all counters 0.
  - All outputs 0; delay line cleared.
  - Reset mid-layer aborts without a done pulse.
- FSM states:
  - IDLE: start goes to RUN with counters zeroed.
  - RUN: on the last tap issued, go to DRAIN.
  - DRAIN: when the delay line is empty, go to DONE.
  - DONE: unconditionally go to IDLE.
- start outside IDLE is ignored.
- Loop order, outermost to innermost: m[0..OUT_CH-1], r, c [0..OUT_SIZE-1], ng[0..NG-1], i, j [0..K-1].
- Counter advance:
  - Counters advance one step per RUN cycle with stall=0.
  - Each counter wraps to 0 and carries into the next outer counter.
- Stall:
  - stall=1 in RUN holds all counters; the next cycle's addr_valid is 0.
  - stall is ignored in IDLE, DRAIN and DONE.
- Address generation (registered, one cycle after the counter state):
  - ifm_addr = ng*IN_SIZE*IN_SIZE + (r+i)*IN_SIZE + (c+j).
  - weight_addr = m*NG*K*K + ng*K*K + i*K + j.
  - Arithmetic is done in ADDR_W+4 bits and truncated to ADDR_W; parameter sets must not overflow.
  - When addr_valid=0, the address outputs hold their last value.
- Timing: start sampled at edge t0 → first addr_valid=1 in the cycle after edge t1 (2-cycle latency).
- Per-tap flags:
  - acc_clear accompanies the tap with i=j=ng=0.
  - acc_last is internal only; it marks the tap with i=j=K-1 and ng=NG-1.
- Output write path:
  - out_addr = m*OUT_SIZE*OUT_SIZE + r*OUT_SIZE + c, captured with acc_last.
  - {acc_last, out_addr} pass through the delay line.
  - out_wea=1 exactly OUT_DELAY cycles after the acc_last tap's addr_valid cycle.
  - The delay line shifts every cycle, independent of stall.
- busy is high from the cycle after start until the DONE cycle; done is high for exactly one cycle, in DONE.
- Total issued taps = OUT_CH*OUT_SIZE²*NG*K² (stall cycles excluded).

Optional Feature:
- Macro: CONV_PERF_CNT_EN.
- Defined:
  - Adds output ports perf_cycles (32) and perf_stalls (32).
  - Both clear on start.
  - perf_cycles counts cycles with busy=1.
  - perf_stalls counts RUN cycles with stall=1.
  - Both hold their values after done; both reset to 0.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package conv_pkg:
  - State enum {IDLE, RUN, DRAIN, DONE}.
  - Default layer constants K, IN_SIZE, OUT_SIZE, IN_CH, OUT_CH, PE_CH.
  - Function to compute NG.
- Sub-module pipe_delay:
  - Parametrised width/depth shift register with async active-low clear.
  - Carries {valid, out_addr} through OUT_DELAY stages.

Test Plan:
- Small layer (K=2, IN_SIZE=4, OUT_SIZE=3, IN_CH=1, OUT_CH=2, PE_CH=4, OUT_DELAY=3):
  - Start → 72 addr_valid cycles.
  - First pixel gives ifm_addr 0,1,4,5 and weight_addr 0,1,2,3.
  - Pixel (r=0,c=1) gives ifm_addr 1,2,5,6.
  - m=1 gives weight_addr 4..7.
- Same layer: out_wea pulses 18 times with out_addr 0..17 in order, each 3 cycles after its 4th tap; done arrives one cycle after the delay line empties.
- stall held high for 5 cycles mid-pixel → addresses frozen, addr_valid 0, tap order unchanged, done delayed by exactly 5 cycles.
- IN_CH=6, PE_CH=4 (NG=2) → 8 taps per pixel; acc_clear only on the ng=0,i=j=0 tap; second group ifm_addr offset by 16.
- rst_n low during RUN → all outputs 0 asynchronously, no done; a later start runs a full clean layer; start pulses while busy are ignored.
- With CONV_PERF_CNT_EN and test 3 → perf_stalls=5, perf_cycles = busy-cycle count.
